// File: rtl/fifo_read_ctrl.sv
`timescale 1ns/1ps
// Read-domain drain controller: pops the async FIFO into a 2-entry output buffer, in bursts or continuously.
// One cycle from pop to out_Valid; pops stall only on a full buffer, so out_Ready never reaches r_Inc combinationally.
module fifo_read_ctrl #(
  parameter int data_Size   = 8,
  parameter int burst_Width = 8,
  parameter int count_Width = 16
) (
  input  logic                   r_Clk,
  input  logic                   r_Rst,
  input  logic                   fifo_Empty,
  input  logic [data_Size-1:0]   read_Data,
  output logic                   r_Inc,
  input  logic                   start,
  input  logic [burst_Width-1:0] burst_Len,
  input  logic                   stop,
  output logic                   out_Valid,
  output logic [data_Size-1:0]   out_Data,
  input  logic                   out_Ready,
  output logic                   busy,
  output logic                   burst_Done,
  output logic [count_Width-1:0] word_Count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [burst_Width-1:0] BURST_ONE = 1;
  localparam logic [count_Width-1:0] COUNT_ONE = 1;

  state_t                 state_q, state_d;
  logic [data_Size-1:0]   buf0_q, buf0_d;
  logic [data_Size-1:0]   buf1_q, buf1_d;
  logic [1:0]             buf_cnt_q, buf_cnt_d;
  logic [burst_Width-1:0] len_q, len_d;
  logic [burst_Width-1:0] pop_cnt_q, pop_cnt_d;
  logic [count_Width-1:0] word_cnt_q, word_cnt_d;
  logic                   done_q, done_d;
  logic                   pop;
  logic                   hs;
  logic                   last_pop;

  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (stop || last_pop) state_d = FLUSH;
      end
      FLUSH: begin
        // Leave as soon as the buffer drains, counting a handshake on this very edge.
        if (buf_cnt_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_Inc = 1'b0;
    busy  = 1'b0;
    case (state_q)
      RUN: begin
        r_Inc = !stop && !fifo_Empty && (buf_cnt_q < 2'd2);
        busy  = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      default: ;
    endcase
  end

  assign pop        = r_Inc;
  assign out_Valid  = (buf_cnt_q != 2'd0);
  assign out_Data   = buf0_q;
  assign hs         = out_Valid && out_Ready;
  assign burst_Done = done_q;
  assign word_Count = word_cnt_q;
  assign last_pop   = pop && (len_q != '0) && ((pop_cnt_q + BURST_ONE) == len_q);

  // buf0 is always the head; buf1 only holds a word when two are queued.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({pop, hs})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = read_Data;
        else                   buf1_d = read_Data;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = read_Data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = read_Data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    pop_cnt_d  = pop_cnt_q;
    word_cnt_d = word_cnt_q;
    if (state_q == IDLE && start) begin
      len_d      = burst_Len;
      pop_cnt_d  = '0;
      word_cnt_d = '0;
    end else begin
      if (pop) pop_cnt_d  = pop_cnt_q + BURST_ONE;
      if (hs)  word_cnt_d = word_cnt_q + COUNT_ONE;
    end
  end

  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      buf_cnt_q  <= 2'd0;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      buf_cnt_q  <= buf_cnt_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
`timescale 1ns/1ps
// Bench for fifo_read_ctrl: directed scenarios plus a randomized run against a queue-based transfer model.
module tb_fifo_read_ctrl;

  logic        r_Clk = 1'b0;
  logic        r_Rst, fifo_Empty, r_Inc, start, stop;
  logic        out_Valid, out_Ready, busy, burst_Done;
  logic [7:0]  read_Data, burst_Len, out_Data;
  logic [15:0] word_Count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fifo_q[$];
  int         m_st;
  logic [7:0] m_buf[$];
  int         m_len, m_pops, m_cnt;
  bit         m_done;

  fifo_read_ctrl #(.data_Size(8), .burst_Width(8), .count_Width(16)) dut (
    .r_Clk(r_Clk), .r_Rst(r_Rst), .fifo_Empty(fifo_Empty), .read_Data(read_Data),
    .r_Inc(r_Inc), .start(start), .burst_Len(burst_Len), .stop(stop),
    .out_Valid(out_Valid), .out_Data(out_Data), .out_Ready(out_Ready),
    .busy(busy), .burst_Done(burst_Done), .word_Count(word_Count)
  );

  always #5 r_Clk = ~r_Clk;

  task automatic drive_fifo();
    fifo_Empty = (fifo_q.size() == 0);
    if (fifo_Empty) read_Data = 8'($urandom);
    else            read_Data = fifo_q[0];
  endtask

  task automatic model_reset();
    m_st = 0; m_buf.delete(); m_len = 0; m_pops = 0; m_cnt = 0; m_done = 0;
  endtask

  function automatic bit model_pop();
    return (m_st == 1) && !stop && (fifo_q.size() > 0) && (m_buf.size() < 2);
  endfunction

  // One clock: the FIFO reacts to the DUT's pop, the model advances by its own rules.
  task automatic tick();
    bit ep, hs, dp;
    logic [7:0] head;
    ep   = model_pop();
    hs   = (m_buf.size() > 0) && (out_Ready === 1'b1);
    dp   = (r_Inc === 1'b1);
    head = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    @(posedge r_Clk);
    if (dp && fifo_q.size() > 0) void'(fifo_q.pop_front());
    m_done = 0;
    case (m_st)
      0: if (start) begin m_st = 1; m_len = int'(burst_Len); m_pops = 0; m_cnt = 0; end
      1: begin
        if (hs) begin void'(m_buf.pop_front()); m_cnt++; end
        if (ep) begin m_buf.push_back(head); m_pops++; end
        if (stop) m_st = 2;
        else if (ep && m_len != 0 && m_pops == m_len) m_st = 2;
      end
      default: begin
        if (hs) begin void'(m_buf.pop_front()); m_cnt++; end
        if (m_buf.size() == 0) begin m_st = 0; m_done = 1; end
      end
    endcase
    @(negedge r_Clk);
    drive_fifo();
  endtask

  task automatic test_reset();
    logic [27:0] o;
    #2 r_Rst = 1'b0;
    model_reset(); fifo_q.delete();
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); stop = 1'($urandom); out_Ready = 1'($urandom);
      burst_Len = 8'($urandom); fifo_Empty = 1'($urandom); read_Data = 8'($urandom);
      #1;
      o = {r_Inc, out_Valid, out_Data, busy, burst_Done, word_Count};
      n_vec++;
      if (o !== 28'd0) begin n_err++; $display("FAIL reset_outputs cycle %0d: got %h want 0", i, o); end
      @(negedge r_Clk);
    end
    start = 0; stop = 0; out_Ready = 1;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); drive_fifo();
    #1 r_Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; n_vec++;
      if (r_Inc !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL release_no_pop cycle %0d: r_Inc=%b busy=%b want 0 0", i, r_Inc, busy);
      end
      tick();
    end
    n_vec++;
    if (fifo_q.size() != 2) begin n_err++; $display("FAIL release_fifo_kept: got %0d want 2", fifo_q.size()); end
    fifo_q.delete(); drive_fifo();
  endtask

  task automatic test_continuous();
    logic [5:0] rinc_pat, vld_pat;
    logic [7:0] got[$];
    int dn;
    fifo_q.delete(); fifo_q.push_back(8'hA5); fifo_q.push_back(8'h3C); fifo_q.push_back(8'h7E);
    out_Ready = 1; burst_Len = 0; stop = 0; start = 1; drive_fifo();
    #1; tick(); start = 0;
    rinc_pat = '0; vld_pat = '0;
    for (int i = 0; i < 6; i++) begin
      #1; rinc_pat[i] = r_Inc; vld_pat[i] = out_Valid;
      if (out_Valid === 1'b1) got.push_back(out_Data);
      tick();
    end
    n_vec++;
    if (rinc_pat !== 6'b000111) begin n_err++; $display("FAIL cont_rinc_pattern: got %b want 000111", rinc_pat); end
    n_vec++;
    if (vld_pat !== 6'b001110) begin n_err++; $display("FAIL cont_valid_pattern: got %b want 001110", vld_pat); end
    n_vec++;
    if (got.size() != 3 || got[0] !== 8'hA5 || got[1] !== 8'h3C || got[2] !== 8'h7E) begin
      n_err++; $display("FAIL cont_data: got %p want A5 3C 7E", got);
    end
    n_vec++;
    if (word_Count !== 16'd3) begin n_err++; $display("FAIL cont_count: got %0d want 3", word_Count); end
    stop = 1; #1; tick(); stop = 0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin #1; if (burst_Done === 1'b1) dn++; tick(); end
    n_vec++;
    if (dn != 1) begin n_err++; $display("FAIL cont_done_pulses: got %0d want 1", dn); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_burst4();
    logic [7:0] w[10];
    logic [7:0] got[$];
    int pulses, dn, last_hs, done_cyc;
    fifo_q.delete();
    for (int i = 0; i < 10; i++) begin w[i] = 8'($urandom); fifo_q.push_back(w[i]); end
    out_Ready = 1; burst_Len = 4; stop = 0; start = 1; drive_fifo();
    #1; tick(); start = 0;
    pulses = 0; dn = 0; last_hs = -1; done_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (r_Inc === 1'b1) pulses++;
      if (out_Valid === 1'b1) begin got.push_back(out_Data); last_hs = i; end
      if (burst_Done === 1'b1) begin dn++; done_cyc = i; end
      tick();
    end
    n_vec++;
    if (pulses != 4) begin n_err++; $display("FAIL burst4_pops: got %0d want 4", pulses); end
    n_vec++;
    if (fifo_q.size() != 6) begin n_err++; $display("FAIL burst4_fifo_left: got %0d want 6", fifo_q.size()); end
    n_vec++;
    if (dn != 1 || done_cyc != last_hs + 1) begin
      n_err++; $display("FAIL burst4_done: pulses %0d at %0d want 1 at %0d", dn, done_cyc, last_hs + 1);
    end
    n_vec++;
    if (word_Count !== 16'd4) begin n_err++; $display("FAIL burst4_count: got %0d want 4", word_Count); end
    n_vec++;
    if (got.size() != 4) begin n_err++; $display("FAIL burst4_words: got %0d want 4", got.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got[k] !== w[k]) begin n_err++; $display("FAIL burst4_data[%0d]: got %h want %h", k, got[k], w[k]); end
    end
    fifo_q.delete(); drive_fifo();
  endtask

  task automatic test_backpressure();
    logic [7:0] w[5];
    logic [7:0] got[$];
    int idx[$];
    int pulses, dn;
    fifo_q.delete();
    for (int i = 0; i < 5; i++) begin w[i] = 8'($urandom); fifo_q.push_back(w[i]); end
    out_Ready = 0; burst_Len = 5; stop = 0; start = 1; drive_fifo();
    #1; tick(); start = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin #1; if (r_Inc === 1'b1) pulses++; tick(); end
    #1; n_vec++;
    if (pulses != 2 || r_Inc !== 1'b0) begin
      n_err++; $display("FAIL bp_stall: pops %0d r_Inc %b want 2 0", pulses, r_Inc);
    end
    n_vec++;
    if (out_Valid !== 1'b1 || out_Data !== w[0]) begin
      n_err++; $display("FAIL bp_hold: valid %b data %h want 1 %h", out_Valid, out_Data, w[0]);
    end
    out_Ready = 1; dn = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_Valid === 1'b1) begin got.push_back(out_Data); idx.push_back(i); end
      if (burst_Done === 1'b1) dn++;
      tick();
    end
    n_vec++;
    if (got.size() != 5) begin n_err++; $display("FAIL bp_words: got %0d want 5", got.size()); end
    else for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (got[k] !== w[k] || idx[k] != idx[0] + k) begin
        n_err++; $display("FAIL bp_data[%0d]: got %h at %0d want %h at %0d", k, got[k], idx[k], w[k], idx[0] + k);
      end
    end
    n_vec++;
    if (dn != 1 || word_Count !== 16'd5) begin
      n_err++; $display("FAIL bp_done: pulses %0d count %0d want 1 5", dn, word_Count);
    end
  endtask

  task automatic test_empty_run();
    int seen, dn;
    fifo_q.delete(); drive_fifo();
    out_Ready = 1; burst_Len = 0; stop = 0; start = 1;
    #1; tick(); start = 0;
    for (int i = 0; i < 4; i++) begin
      #1; n_vec++;
      if (r_Inc !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL empty_wait cycle %0d: r_Inc %b busy %b want 0 1", i, r_Inc, busy);
      end
      tick();
    end
    fifo_q.push_back(8'h5A); drive_fifo();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_Valid === 1'b1) begin
        seen++; n_vec++;
        if (out_Data !== 8'h5A) begin n_err++; $display("FAIL empty_data: got %h want 5a", out_Data); end
      end
      tick();
    end
    n_vec++;
    if (seen != 1 || fifo_q.size() != 0) begin
      n_err++; $display("FAIL empty_single: seen %0d left %0d want 1 0", seen, fifo_q.size());
    end
    stop = 1; #1; tick(); stop = 0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin #1; if (burst_Done === 1'b1) dn++; tick(); end
    n_vec++;
    if (dn != 1 || busy !== 1'b0) begin n_err++; $display("FAIL empty_stop: pulses %0d busy %b want 1 0", dn, busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w[3];
    logic [7:0] got[$];
    int hsn, dn;
    fifo_q.delete();
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
    out_Ready = 1; burst_Len = 8; stop = 0; start = 1; drive_fifo();
    #1; tick(); start = 0;
    hsn = 0;
    for (int i = 0; i < 12 && hsn < 3; i++) begin #1; if (out_Valid === 1'b1) hsn++; tick(); end
    n_vec++;
    if (hsn != 3) begin n_err++; $display("FAIL rmid_handshakes: got %0d want 3", hsn); end
    #2 r_Rst = 1'b0;
    #1; n_vec++;
    if ({out_Valid, busy, word_Count} !== 18'd0) begin
      n_err++; $display("FAIL rmid_async_clear: valid %b busy %b count %0d want 0", out_Valid, busy, word_Count);
    end
    model_reset(); fifo_q.delete();
    for (int i = 0; i < 3; i++) begin w[i] = 8'($urandom); fifo_q.push_back(w[i]); end
    @(negedge r_Clk); r_Rst = 1'b1;
    burst_Len = 3; start = 1; drive_fifo();
    #1; tick(); start = 0;
    #1; n_vec++;
    if (word_Count !== 16'd0) begin n_err++; $display("FAIL rmid_fresh_count: got %0d want 0", word_Count); end
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_Valid === 1'b1) got.push_back(out_Data);
      if (burst_Done === 1'b1) dn++;
      tick();
    end
    n_vec++;
    if (got.size() != 3 || got[0] !== w[0] || got[1] !== w[1] || got[2] !== w[2]) begin
      n_err++; $display("FAIL rmid_fresh_data: got %p want %h %h %h", got, w[0], w[1], w[2]);
    end
    n_vec++;
    if (dn != 1 || word_Count !== 16'd3) begin n_err++; $display("FAIL rmid_fresh_end: pulses %0d count %0d want 1 3", dn, word_Count); end
  endtask

  task automatic test_max_burst();
    int pulses, dn;
    fifo_q.delete();
    for (int i = 0; i < 300; i++) fifo_q.push_back(8'(i));
    out_Ready = 1; burst_Len = 8'd255; stop = 0; start = 1; drive_fifo();
    #1; tick(); start = 0;
    pulses = 0; dn = 0;
    for (int i = 0; i < 400 && dn == 0; i++) begin
      #1;
      if (r_Inc === 1'b1) pulses++;
      if (burst_Done === 1'b1) dn++;
      tick();
    end
    n_vec++;
    if (dn != 1) begin n_err++; $display("FAIL max_done: no burst_Done within 400 cycles"); end
    n_vec++;
    if (pulses != 255 || fifo_q.size() != 45) begin
      n_err++; $display("FAIL max_pops: pops %0d left %0d want 255 45", pulses, fifo_q.size());
    end
    n_vec++;
    if (word_Count !== 16'd255) begin n_err++; $display("FAIL max_count: got %0d want 255", word_Count); end
    fifo_q.delete(); drive_fifo();
  endtask

  task automatic test_random();
    fifo_q.delete(); drive_fifo();
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      burst_Len = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      stop      = ($urandom_range(0, 29) == 0);
      out_Ready = ($urandom_range(0, 9) < 7);
      if (fifo_q.size() < 20 && $urandom_range(0, 9) < 6) fifo_q.push_back(8'($urandom));
      drive_fifo();
      #1;
      n_vec++;
      if (r_Inc !== model_pop()) begin n_err++; $display("FAIL rand_rinc @%0d: got %b want %b", c, r_Inc, model_pop()); end
      n_vec++;
      if (out_Valid !== (m_buf.size() > 0)) begin
        n_err++; $display("FAIL rand_valid @%0d: got %b want %b", c, out_Valid, m_buf.size() > 0);
      end
      if (m_buf.size() > 0) begin
        n_vec++;
        if (out_Data !== m_buf[0]) begin n_err++; $display("FAIL rand_data @%0d: got %h want %h", c, out_Data, m_buf[0]); end
      end
      n_vec++;
      if (busy !== (m_st != 0)) begin n_err++; $display("FAIL rand_busy @%0d: got %b want %b", c, busy, m_st != 0); end
      n_vec++;
      if (burst_Done !== m_done) begin n_err++; $display("FAIL rand_done @%0d: got %b want %b", c, burst_Done, m_done); end
      n_vec++;
      if (word_Count !== 16'(m_cnt)) begin
        n_err++; $display("FAIL rand_count @%0d: got %0d want %0d", c, word_Count, 16'(m_cnt));
      end
      tick();
    end
  endtask

  initial begin
    r_Rst = 1'b1; start = 0; stop = 0; out_Ready = 0; burst_Len = 0;
    fifo_Empty = 1; read_Data = 0;
    model_reset();
    test_reset();
    test_continuous();
    test_burst4();
    test_backpressure();
    test_empty_run();
    test_reset_mid();
    test_max_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side drain controller for the asynchronous FIFO, living entirely in the read clock domain. It watches the FIFO read port (`fifo_Empty`, `read_Data`) and issues `r_Inc` pops. Popped words are delivered in order on a valid/ready output stream through a 2-entry buffer. It supports fixed-length bursts and a continuous mode, and keeps a running delivered-word count.

## Interface
- `data_Size`, 8, FIFO word width in bits.
- `burst_Width`, 8, width of `burst_Len`.
- `count_Width`, 16, width of `word_Count`.

- `r_Clk`  in  1  read-domain clock; only clock of the block.
- `r_Rst`  in  1  reset, asynchronous, active-low.
- `fifo_Empty`  in  1  FIFO read-side empty flag.
- `read_Data`  in  data_Size  FIFO head word, valid whenever `fifo_Empty`=0.
- `r_Inc`  out  1  pop strobe to FIFO; head word consumed at the `r_Clk` rising edge where `r_Inc`=1.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `burst_Len`  in  burst_Width  words to drain; 0 = continuous; latched on accepted `start`.
- `stop`  in  1  end continuous or burst run early.
- `out_Valid`  out  1  `out_Data` holds a word.
- `out_Data`  out  data_Size  head of output buffer.
- `out_Ready`  in  1  downstream accepts; handshake = `out_Valid` & `out_Ready` at rising edge.
- `busy`  out  1  state ≠ IDLE.
- `burst_Done`  out  1  one-cycle pulse on FLUSH→IDLE.
- `word_Count`  out  count_Width  output handshakes since last accepted `start`.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE, `start`=1:
  - → RUN.
  - Latch `burst_Len` into `len_q`; clear `pop_cnt` and `word_Count`.
  - `start` is ignored in RUN and FLUSH.
- Pop rule: `r_Inc` = (state==RUN) & !`stop` & !`fifo_Empty` & (`buf_cnt` < 2).
  - `buf_cnt` is the registered occupancy, 0..2.
  - No combinational path from `out_Ready` to `r_Inc`.
- On a pop, `read_Data` is written into the buffer tail.
- Buffer behaviour:
  - Strict FIFO order.
  - Simultaneous pop and output handshake leaves `buf_cnt` unchanged.
  - Full throughput is one word per cycle.
- `pop_cnt` increments per pop. RUN → FLUSH when either:
  - `len_q`≠0 and a pop occurs with `pop_cnt`+1 == `len_q`, or
  - `stop`=1 in RUN (no pop in that cycle).
- FLUSH:
  - No pops.
  - When `buf_cnt` reaches 0 (including via a handshake in the current cycle) → IDLE, with `burst_Done`=1 for the next cycle only.
  - `stop` has no further effect.
- Continuous mode (`len_q`=0) leaves RUN only via `stop`.
- RUN with `fifo_Empty`=1: remains in RUN, `r_Inc`=0, `busy`=1. No timeout.
- `word_Count`:
  - Increments on each output handshake.
  - Wraps modulo 2^count_Width.
  - Holds its value in IDLE.
- `pop_cnt` is burst_Width bits. `len_q`=2^burst_Width−1 is the maximum burst.

## Timing
- Reset (`r_Rst`=0, asynchronous): state IDLE, `buf_cnt`=0, `out_Valid`=0, `out_Data`=0, `busy`=0, `burst_Done`=0, `word_Count`=0, `pop_cnt`=0, `len_q`=0. `r_Inc`=0 immediately, combinationally via state.
- Reset mid-transfer discards buffered words. Words already popped from the FIFO are lost by design.
- Accepted `start` at edge N: `busy`=1 and the first `r_Inc` possible in cycle N+1.
- Pop at edge N: word visible on `out_Data` with `out_Valid`=1 in cycle N+1 (1-cycle latency).
- `out_Data` and `out_Valid` are stable while `out_Valid`=1 and `out_Ready`=0.
- `burst_Done` is registered: high for the cycle after the last output handshake of the transfer.
- `busy` falls in the same cycle `burst_Done` rises.

## Test plan
- Reset with all inputs toggling:
  - All outputs 0.
  - `r_Inc` never asserts until `start`.
  - Releasing `r_Rst` gives no spurious pop.
- Continuous drain:
  - Stimulus: FIFO holds A5, 3C, 7E; `start`=1 with `burst_Len`=0; `out_Ready`=1.
  - `r_Inc` high 3 consecutive cycles.
  - `out_Data` = A5, 3C, 7E on consecutive cycles.
  - `word_Count`=3.
  - Then `stop` → `burst_Done` pulse → IDLE.
- Burst of 4 with 10 words queued:
  - Exactly 4 `r_Inc` pulses; FIFO retains 6.
  - `burst_Done` pulses once, one cycle after the 4th handshake.
  - `word_Count`=4.
- Backpressure:
  - Stimulus: `out_Ready`=0 from `start` with 5 words queued.
  - After 2 pops `r_Inc` stays 0; `out_Data` holds word 0.
  - Raise `out_Ready`: words 0–4 arrive in order, no gaps after the first, none lost or duplicated.
- Empty FIFO in RUN:
  - `r_Inc` stays 0, `busy`=1.
  - Write 1 word (5A): popped, out_Data=5A.
  - `stop` → IDLE with a single `burst_Done` pulse.
- Reset mid-burst:
  - Stimulus: `burst_Len`=8, `r_Rst` pulled low after 3 handshakes.
  - `out_Valid`, `busy` and `word_Count` go to 0 asynchronously.
  - Next `start` begins a fresh burst with `word_Count` from 0.
